column_writer: RTL

COLUMN_WRITER -- requirements
Module: column_writer

---
 rtl/raycast_pkg.sv | 18 +
 rtl/column_writer_if.sv | 34 +++
 rtl/divu.sv | 67 ++++++
 rtl/column_writer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared raycaster constants, colours and the column-writer state type.
package raycast_pkg;

    localparam int          SCREEN_WIDTH_DEF  = 320;
    localparam int          SCREEN_HEIGHT_DEF = 180;
    localparam int          TEX_SIZE          = 64;
    localparam logic [7:0]  CEIL_COLOR_DEF    = 8'h01;
    localparam logic [7:0]  FLOOR_COLOR_DEF   = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_DIV,
        S_DRAW,
        S_DONE
    } cw_state_t;

endpackage

// File: rtl/column_writer_if.sv
// Column-result, framebuffer and status bundle of the column writer.
interface column_writer_if;

    logic [8:0]  hcount_ray_in;
    logic [7:0]  lineHeight_in;
    logic        wallType_in;
    logic [4:0]  mapData_in;
    logic [15:0] wallX_in;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] fb_addr_out;
    logic [7:0]  fb_data_out;
    logic        fb_we_out;
    logic        fb_ready_in;
    logic [5:0]  tex_u_out;
    logic [5:0]  tex_v_out;
    logic        busy_out;
    logic        column_done_out;

    modport slave (
        input  hcount_ray_in, lineHeight_in, wallType_in,
        input  mapData_in, wallX_in, valid_in, fb_ready_in,
        output ready_out, fb_addr_out, fb_data_out, fb_we_out,
        output tex_u_out, tex_v_out, busy_out, column_done_out
    );

    modport master (
        output hcount_ray_in, lineHeight_in, wallType_in,
        output mapData_in, wallX_in, valid_in, fb_ready_in,
        input  ready_out, fb_addr_out, fb_data_out, fb_we_out,
        input  tex_u_out, tex_v_out, busy_out, column_done_out
    );

endinterface

// File: rtl/divu.sv
// Unsigned restoring divider: o_val = (i_a << FBITS) / i_b,
// one quotient bit per cycle, o_done pulses when o_val is ready.
module divu #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_val
);

    localparam int N  = WIDTH + FBITS;
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]     r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;

    assign w_sh   = {r_rem, r_q[N-1]};
    assign w_diff = w_sh - {1'b0, r_b};
    assign o_done = r_done;
    assign o_val  = r_q[WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_q    <= {i_a, {FBITS{1'b0}}};
                r_rem  <= '0;
                r_b    <= i_b;
                r_cnt  <= CW'(N);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                // borrow out of the top bit means the trial subtract failed
                if (!w_diff[WIDTH]) begin
                    r_rem <= w_diff[WIDTH-1:0];
                    r_q   <= {r_q[N-2:0], 1'b1};
                end else begin
                    r_rem <= w_sh[WIDTH-1:0];
                    r_q   <= {r_q[N-2:0], 1'b0};
                end
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/column_writer.sv
// Paints one screen column (ceiling / wall / floor) into the framebuffer.
// Optional texture coordinates: define COLUMN_WRITER_TEXTURE_EN.
module column_writer
    import raycast_pkg::*;
#(
    parameter int         SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int         SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter logic [7:0] CEIL_COLOR    = CEIL_COLOR_DEF,
    parameter logic [7:0] FLOOR_COLOR   = FLOOR_COLOR_DEF
) (
    input  logic            pixel_clk_in,
    input  logic            rst_n_in,
    column_writer_if.slave  bus
);

    localparam logic [7:0]  H8  = 8'(SCREEN_HEIGHT);
    localparam logic [15:0] W16 = 16'(SCREEN_WIDTH);

    cw_state_t   r_state;
    cw_state_t   w_next;
    logic [8:0]  r_hcount;
    logic [7:0]  r_lh;
    logic        r_wall_type;
    logic [4:0]  r_map;
    logic [7:0]  r_draw_start;
    logic [7:0]  r_draw_end;
    logic [7:0]  r_y;
    logic [15:0] r_addr;
    logic [7:0]  w_lh_clamp;
    logic [7:0]  w_ds;
    logic        w_capture;
    logic        w_accept;
    logic        w_last;
    logic        w_wall;
    logic [7:0]  w_color;
    logic        w_div_done;

    assign w_lh_clamp = (bus.lineHeight_in > H8) ? H8 : bus.lineHeight_in;
    assign w_ds       = (H8 - r_lh) >> 1;
    assign w_capture  = (r_state == S_IDLE) && bus.valid_in;
    assign w_accept   = (r_state == S_DRAW) && bus.fb_ready_in;
    assign w_last     = (r_y == H8 - 8'd1);
    assign w_wall     = (r_y >= r_draw_start) && (r_y < r_draw_end);

    always_comb begin
        w_color = FLOOR_COLOR;
        if (r_y < r_draw_start)
            w_color = CEIL_COLOR;
        else if (w_wall)
            w_color = {r_wall_type, 2'b00, r_map};
    end

`ifdef COLUMN_WRITER_TEXTURE_EN
    logic [15:0] r_acc;
    logic [15:0] r_step;
    logic [15:0] w_quo;
    logic [5:0]  r_tex_u;
    logic        w_div_start;
    logic        w_unused_wx;

    assign w_div_start = (r_state == S_SETUP) && (r_lh != 8'd0);
    assign w_unused_wx = ^{bus.wallX_in[15:8], bus.wallX_in[1:0]};

    divu #(
        .WIDTH(16),
        .FBITS(8)
    ) u_divu (
        .i_clk   (pixel_clk_in),
        .i_rst_n (rst_n_in),
        .i_start (w_div_start),
        .i_a     (16'(TEX_SIZE)),
        .i_b     ({8'd0, r_lh}),
        .o_done  (w_div_done),
        .o_val   (w_quo)
    );

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            r_acc   <= '0;
            r_step  <= '0;
            r_tex_u <= '0;
        end else begin
            if (w_capture)
                r_tex_u <= bus.wallX_in[7:2];
            if (r_state == S_SETUP)
                r_acc <= '0;
            if ((r_state == S_WAIT_DIV) && w_div_done)
                r_step <= w_quo;
            if (w_accept && w_wall)
                r_acc <= r_acc + r_step;
        end
    end

    assign bus.tex_u_out = (r_state == S_DRAW) ? r_tex_u : 6'd0;
    assign bus.tex_v_out = (r_state == S_DRAW) ? r_acc[13:8] : 6'd0;
`else
    logic w_unused_wx;

    assign w_unused_wx   = ^bus.wallX_in;
    assign w_div_done    = 1'b1;
    assign bus.tex_u_out = 6'd0;
    assign bus.tex_v_out = 6'd0;
`endif

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_capture)
                    w_next = S_SETUP;
            S_SETUP: begin
`ifdef COLUMN_WRITER_TEXTURE_EN
                // a zero-height wall has no rows to texture
                w_next = (r_lh == 8'd0) ? S_DRAW : S_WAIT_DIV;
`else
                w_next = S_DRAW;
`endif
            end
            S_WAIT_DIV:
                if (w_div_done)
                    w_next = S_DRAW;
            S_DRAW:
                if (w_accept && w_last)
                    w_next = S_DONE;
            S_DONE:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_out       = (r_state == S_IDLE);
        bus.busy_out        = (r_state != S_IDLE);
        bus.fb_we_out       = (r_state == S_DRAW);
        bus.column_done_out = (r_state == S_DONE);
        bus.fb_addr_out     = (r_state == S_DRAW) ? r_addr : 16'd0;
        bus.fb_data_out     = (r_state == S_DRAW) ? w_color : 8'd0;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            r_hcount     <= '0;
            r_lh         <= '0;
            r_wall_type  <= 1'b0;
            r_map        <= '0;
            r_draw_start <= '0;
            r_draw_end   <= '0;
            r_y          <= '0;
            r_addr       <= '0;
        end else begin
            if (w_capture) begin
                r_hcount    <= bus.hcount_ray_in;
                r_lh        <= w_lh_clamp;
                r_wall_type <= bus.wallType_in;
                r_map       <= bus.mapData_in;
            end
            if (r_state == S_SETUP) begin
                r_draw_start <= w_ds;
                r_draw_end   <= w_ds + r_lh;
                r_y          <= '0;
                r_addr       <= {7'd0, r_hcount};
            end
            if (w_accept) begin
                r_y    <= r_y + 8'd1;
                r_addr <= r_addr + W16;
            end
        end
    end

endmodule
